// File: rtl/traffic_pkg.sv
// Shared types, lamp codes and phase-duration helpers for the traffic phase sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    STOP = 3'd0,
    NS_G = 3'd1,
    NS_Y = 3'd2,
    AR_A = 3'd3,
    EW_G = 3'd4,
    EW_Y = 3'd5,
    AR_B = 3'd6
  } phase_e;

  // Lamp bundles are {R,Y,G}
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // STOP reports a one-second "duration" so that its remain value is always 0.
  function automatic int phase_dur(phase_e p, int green_sec, int yellow_sec, int allred_sec);
    case (p)
      NS_G, EW_G: return green_sec;
      NS_Y, EW_Y: return yellow_sec;
      AR_A, AR_B: return allred_sec;
      default:    return 1;
    endcase
  endfunction

  function automatic phase_e next_phase(phase_e p);
    case (p)
      AR_B:    return NS_G;
      NS_G:    return NS_Y;
      NS_Y:    return AR_A;
      AR_A:    return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return AR_B;
      default: return AR_B;
    endcase
  endfunction

  function automatic int remain_width(int green_sec, int yellow_sec, int allred_sec);
    int max_sec;
    int w;
    max_sec = green_sec;
    if (yellow_sec > max_sec) max_sec = yellow_sec;
    if (allred_sec > max_sec) max_sec = allred_sec;
    w = $clog2(max_sec);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// Loadable down counter holding the seconds left in the current phase; load wins over tick.
module phase_timer #(
  parameter int           W       = 5,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] remain,
  output logic         zero
);

  logic [W-1:0] remain_q;
  logic [W-1:0] remain_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    remain_d = remain_q;
    if (load) begin
      remain_d = load_val;
    end else if (tick && (remain_q != '0)) begin
      remain_d = remain_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) remain_q <= RST_VAL;
    else     remain_q <= remain_d;
  end

  assign remain = remain_q;
  assign zero   = (remain_q == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Six-phase two-way intersection controller driven by the seconds-counter tick.
// Optional build macro TLC_FLASH_EN turns STOP into a flashing-yellow mode.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int pGREEN_SEC  = 25,
  parameter int pYELLOW_SEC = 3,
  parameter int pALLRED_SEC = 2,
  localparam int W = remain_width(pGREEN_SEC, pYELLOW_SEC, pALLRED_SEC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         sec_last,
  input  logic         sec_pre_last,
  output logic         sec_en,
  output logic [2:0]   ns_light,
  output logic [2:0]   ew_light,
  output logic [2:0]   phase,
  output logic [W-1:0] remain,
  output logic         phase_pre_end
);

  localparam logic [W-1:0] ALLRED_M1 = W'(pALLRED_SEC - 1);

  phase_e       state_q, state_d;
  logic [2:0]   ns_q, ns_d;
  logic [2:0]   ew_q, ew_d;
  logic         tmr_load, tmr_tick, tmr_zero;
  logic [W-1:0] tmr_load_val;
  logic [W-1:0] remain_q;

`ifdef TLC_FLASH_EN
  logic flash_q, flash_d;
`endif

  function automatic logic [W-1:0] dur_m1(phase_e p);
    return W'(phase_dur(p, pGREEN_SEC, pYELLOW_SEC, pALLRED_SEC) - 1);
  endfunction

  phase_timer #(
    .W       (W),
    .RST_VAL (ALLRED_M1)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tmr_tick),
    .remain   (remain_q),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_tick     = 1'b0;
    if (!run) begin
      state_d  = STOP;
      tmr_load = 1'b1;
    end else if (state_q == STOP) begin
      // Leaving STOP always passes through clearance before any green.
      state_d      = AR_B;
      tmr_load     = 1'b1;
      tmr_load_val = ALLRED_M1;
    end else if (sec_last) begin
      if (tmr_zero) begin
        state_d      = next_phase(state_q);
        tmr_load     = 1'b1;
        tmr_load_val = dur_m1(next_phase(state_q));
      end else begin
        tmr_tick = 1'b1;
      end
    end
  end

`ifdef TLC_FLASH_EN
  // Flash restarts lit on every entry to STOP, then toggles once per second.
  always_comb begin
    flash_d = flash_q;
    if (state_q != STOP) flash_d = 1'b1;
    else if (sec_last)   flash_d = ~flash_q;
  end
`endif

  // Lamps are decoded from the next state so they change on the same edge as the phase.
  always_comb begin
    ns_d = LAMP_R;
    ew_d = LAMP_R;
    case (state_d)
      NS_G: ns_d = LAMP_G;
      NS_Y: ns_d = LAMP_Y;
      EW_G: ew_d = LAMP_G;
      EW_Y: ew_d = LAMP_Y;
`ifdef TLC_FLASH_EN
      STOP: begin
        ns_d = flash_d ? LAMP_Y : LAMP_OFF;
        ew_d = flash_d ? LAMP_Y : LAMP_OFF;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= AR_B;
      ns_q    <= LAMP_R;
      ew_q    <= LAMP_R;
`ifdef TLC_FLASH_EN
      flash_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
`ifdef TLC_FLASH_EN
      flash_q <= flash_d;
`endif
    end
  end

`ifdef TLC_FLASH_EN
  assign sec_en = !rst;
`else
  assign sec_en = !rst && (state_q != STOP);
`endif

  assign phase_pre_end = !rst && tmr_zero && sec_pre_last;
  assign ns_light      = ns_q;
  assign ew_light      = ew_q;
  assign phase         = state_q;
  assign remain        = remain_q;

  a_no_conflict: assert property (@(posedge clk) disable iff (rst)
    !(((ns_q == LAMP_G) || (ew_q == LAMP_G)) && (ns_q != LAMP_R) && (ew_q != LAMP_R)));

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor pops and compares.
module tb_traffic_phase_sequencer;
  import traffic_pkg::*;

  localparam int G = 3;
  localparam int Y = 2;
  localparam int A = 1;
  localparam int W = remain_width(G, Y, A);

`ifdef TLC_FLASH_EN
  localparam logic STOP_SEN = 1'b1;
`else
  localparam logic STOP_SEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, run, sec_last, sec_pre_last;
  logic         sec_en, phase_pre_end;
  logic [2:0]   ns_light, ew_light, phase;
  logic [W-1:0] remain;

  traffic_phase_sequencer #(
    .pGREEN_SEC  (G),
    .pYELLOW_SEC (Y),
    .pALLRED_SEC (A)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .sec_last      (sec_last),
    .sec_pre_last  (sec_pre_last),
    .sec_en        (sec_en),
    .ns_light      (ns_light),
    .ew_light      (ew_light),
    .phase         (phase),
    .remain        (remain),
    .phase_pre_end (phase_pre_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] ph;
    logic [2:0] ns;
    logic [2:0] ew;
    int         rem;
    logic       sen;
    logic       pe;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   viol  = 0;
  bit   rand_mode = 1'b0;

  // Hand-derived phase/remain for each second of the 3/2/1 schedule, starting from AR_B.
  phase_e seq_ph  [14] = '{AR_B, NS_G, NS_G, NS_G, NS_Y, NS_Y, AR_A,
                           EW_G, EW_G, EW_G, EW_Y, EW_Y, AR_B, NS_G};
  int     seq_rem [14] = '{0, 2, 1, 0, 1, 0, 0, 2, 1, 0, 1, 0, 0, 2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [2:0] ns_of(phase_e p);
    case (p)
      NS_G:    return LAMP_G;
      NS_Y:    return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] ew_of(phase_e p);
    case (p)
      EW_G:    return LAMP_G;
      EW_Y:    return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] stop_lamp(int k);
`ifdef TLC_FLASH_EN
    return (k % 2 == 0) ? LAMP_Y : LAMP_OFF;
`else
    return LAMP_R;
`endif
  endfunction

  function automatic int exp_dur(logic [2:0] p);
    case (p)
      3'd1, 3'd4: return G;
      3'd2, 3'd5: return Y;
      3'd3, 3'd6: return A;
      default:    return 1;
    endcase
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show during that cycle.
  task automatic cyc_push(input logic r, input logic rn, input logic sl, input logic spl,
                          input phase_e ph, input logic [2:0] ns, input logic [2:0] ew,
                          input int rem, input logic sen, input logic pe);
    exp_t x;
    rst = r; run = rn; sec_last = sl; sec_pre_last = spl;
    x.cyc = cyc; x.ph = ph; x.ns = ns; x.ew = ew; x.rem = rem; x.sen = sen; x.pe = pe;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  // Ten clocks per second: sec_pre_last on clock 8, sec_last on clock 9.
  task automatic run_seq(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      for (int j = 0; j < 10; j++) begin
        cyc_push(1'b0, 1'b1, (j == 9), (j == 8), seq_ph[k], ns_of(seq_ph[k]),
                 ew_of(seq_ph[k]), seq_rem[k], 1'b1, (j == 8) && (seq_rem[k] == 0));
      end
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check("phase",     phase,         e.ph);
      check("ns_light",  ns_light,      e.ns);
      check("ew_light",  ew_light,      e.ew);
      check("remain",    remain,        e.rem);
      check("sec_en",    sec_en,        e.sen);
      check("pre_end",   phase_pre_end, e.pe);
    end
    if (rand_mode && !rst) begin
      if (!$onehot0(ns_light) || !$onehot0(ew_light)) viol++;
      if (((ns_light == LAMP_G) || (ew_light == LAMP_G)) &&
          (ns_light != LAMP_R) && (ew_light != LAMP_R)) viol++;
      if (int'(remain) > exp_dur(phase) - 1) viol++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; run = 1'b1; sec_last = 1'b0; sec_pre_last = 1'b0;
    @(posedge clk); #1;
    cyc_push(1'b1, 1'b1, 1'b0, 1'b0, AR_B, LAMP_R, LAMP_R, 0, 1'b0, 1'b0);

    run_seq(0, 13);

    // run falls together with a tick at NS_G remain=1: the tick is dropped.
    cyc_push(1'b0, 1'b0, 1'b1, 1'b0, NS_G, LAMP_G, LAMP_R, 1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc_push(1'b0, 1'b0, (j == 2), 1'b0, STOP, stop_lamp(k), stop_lamp(k), 0, STOP_SEN, 1'b0);
      end
    end
    cyc_push(1'b0, 1'b1, 1'b0, 1'b0, STOP, stop_lamp(4), stop_lamp(4), 0, STOP_SEN, 1'b0);

    // Restart lands in AR_B; run up to EW_Y remain=1 and reset mid-phase.
    run_seq(0, 9);
    for (int j = 0; j < 4; j++) begin
      cyc_push(1'b0, 1'b1, 1'b0, 1'b0, EW_Y, LAMP_R, LAMP_Y, 1, 1'b1, 1'b0);
    end
    cyc_push(1'b1, 1'b1, 1'b0, 1'b0, EW_Y, LAMP_R, LAMP_Y, 1, 1'b0, 1'b0);
    cyc_push(1'b0, 1'b1, 1'b0, 1'b0, AR_B, LAMP_R, LAMP_R, 0, 1'b1, 1'b0);

    rand_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      rst          = 1'b0;
      run          = ($urandom_range(0, 15) != 0);
      sec_last     = ($urandom_range(0, 3) == 0);
      sec_pre_last = $urandom_range(0, 1) == 1;
      @(posedge clk); #1;
    end
    rand_mode = 1'b0;
    @(negedge clk); #1;

    check("rand_invariants", viol, 0);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
